uart_rx: RTL and testbench

UART_RX -- requirements
Module: uart_rx

---
 rtl/uart_rx_if.sv | 28 ++
 rtl/uart_rx.sv | 228 ++++++++++++++++++++++
 tb/tb_uart_rx.sv | 291 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_rx_if.sv
// Receive-side handshake bundle for uart_rx: byte/valid/ready plus the error pulses.
// The receiver uses the master modport; the byte consumer uses the slave modport.
interface uart_rx_if;
  logic       rx_valid;
  logic [7:0] rx_data;
  logic       rx_ready;
  logic       frame_err;
  logic       overrun;
  logic       parity_err;

  modport master (
    output rx_valid,
    output rx_data,
    output frame_err,
    output overrun,
    output parity_err,
    input  rx_ready
  );

  modport slave (
    input  rx_valid,
    input  rx_data,
    input  frame_err,
    input  overrun,
    input  parity_err,
    output rx_ready
  );
endinterface

// File: rtl/uart_rx.sv
// uart_rx: oversampling-free UART receiver (8N1 by default) with a one-byte
// valid/ready output buffer and single-cycle error pulses.
// Define UART_RX_PARITY_EN to receive 8E1 frames and report parity errors.
// clk_hz / baud_rate must be at least 4.
module uart_rx #(
  parameter int clk_hz    = 50_000_000,
  parameter int baud_rate = 115_200
) (
  input  logic      clk,
  input  logic      rst_n,
  input  logic      rxd,
  uart_rx_if.master rx
);

  localparam int            CLKS_PER_BIT = clk_hz / baud_rate;
  localparam int            TW           = $clog2(CLKS_PER_BIT);
  localparam logic [TW-1:0] BIT_RELOAD   = TW'(CLKS_PER_BIT - 1);
  localparam logic [TW-1:0] HALF_RELOAD  = TW'(CLKS_PER_BIT / 2 - 1);

`ifdef UART_RX_PARITY_EN
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_e;
`else
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_e;
`endif

  // Synchronizer and edge detection
  logic       sync1_q, sync1_d;
  logic       rxs_q, rxs_d;
  logic [1:0] sync_vld_q, sync_vld_d;
  logic       rxs_prev_q, rxs_prev_d;
  logic       fall;

  // Frame FSM and datapath
  state_e        state_q, state_d;
  logic [TW-1:0] timer_q, timer_d;
  logic [2:0]    bit_idx_q, bit_idx_d;
  logic [7:0]    shift_q, shift_d;
  logic          tick;
  logic          stop_sample;
  logic          par_bad;
`ifdef UART_RX_PARITY_EN
  logic          par_bit_q, par_bit_d;
`endif

  // Output buffer and pulses
  logic       rx_valid_q, rx_valid_d;
  logic [7:0] rx_data_q, rx_data_d;
  logic       frame_err_q, frame_err_d;
  logic       overrun_q, overrun_d;
`ifdef UART_RX_PARITY_EN
  logic       parity_err_q, parity_err_d;
`endif

  // Synchronizer next values; sync_vld marks when rxs reflects the real line
  // rather than its reset value, so a line that is low at reset release does
  // not look like a falling edge.
  always_comb begin
    sync1_d    = rxd;
    rxs_d      = sync1_q;
    sync_vld_d = {sync_vld_q[0], 1'b1};
    rxs_prev_d = sync_vld_q[1] & rxs_q;
  end

  assign fall = rxs_prev_q & ~rxs_q;

  // Synchronizer registers; idle-high line, so the chain resets to 1
  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q    <= 1'b1;
      rxs_q      <= 1'b1;
      sync_vld_q <= 2'b00;
      rxs_prev_q <= 1'b0;
    end else begin
      sync1_q    <= sync1_d;
      rxs_q      <= rxs_d;
      sync_vld_q <= sync_vld_d;
      rxs_prev_q <= rxs_prev_d;
    end
  end

  assign tick        = (timer_q == '0);
  assign stop_sample = (state_q == STOP) && tick;

`ifdef UART_RX_PARITY_EN
  // Even parity: data bits and parity bit must XOR to zero
  assign par_bad = ^{shift_q, par_bit_q};
`else
  assign par_bad = 1'b0;
`endif

  // FSM state register with its bit timer, bit index and shift register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      timer_q   <= '0;
      bit_idx_q <= '0;
      shift_q   <= '0;
`ifdef UART_RX_PARITY_EN
      par_bit_q <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      timer_q   <= timer_d;
      bit_idx_q <= bit_idx_d;
      shift_q   <= shift_d;
`ifdef UART_RX_PARITY_EN
      par_bit_q <= par_bit_d;
`endif
    end
  end

  // Next-state logic: timer counts down to zero, reloads on every state entry
  always_comb begin
    // NOTE: every combinational output gets a default first so no path
    // through the case leaves it unassigned and infers a latch.
    state_d   = state_q;
    bit_idx_d = bit_idx_q;
    shift_d   = shift_q;
    timer_d   = tick ? timer_q : timer_q - TW'(1);
`ifdef UART_RX_PARITY_EN
    par_bit_d = par_bit_q;
`endif
    case (state_q)
      IDLE: begin
        if (fall) begin
          state_d = START;
          timer_d = HALF_RELOAD;
        end
      end
      START: begin
        if (tick) begin
          if (!rxs_q) begin
            state_d   = DATA;
            timer_d   = BIT_RELOAD;
            bit_idx_d = '0;
          end else begin
            state_d = IDLE;
          end
        end
      end
      DATA: begin
        if (tick) begin
          shift_d   = {rxs_q, shift_q[7:1]};
          bit_idx_d = bit_idx_q + 3'd1;
          timer_d   = BIT_RELOAD;
          if (bit_idx_q == 3'd7) begin
`ifdef UART_RX_PARITY_EN
            state_d = PARITY;
`else
            state_d = STOP;
`endif
          end
        end
      end
`ifdef UART_RX_PARITY_EN
      PARITY: begin
        if (tick) begin
          par_bit_d = rxs_q;
          state_d   = STOP;
          timer_d   = BIT_RELOAD;
        end
      end
`endif
      STOP: begin
        if (tick) state_d = IDLE;
      end
      default: begin
        state_d   = IDLE;
        timer_d   = '0;
        bit_idx_d = '0;
      end
    endcase
  end

  // Output logic: frame verdict at the stop sample plus the valid/ready buffer
  always_comb begin
    rx_valid_d  = rx_valid_q;
    rx_data_d   = rx_data_q;
    frame_err_d = stop_sample & ~rxs_q;
    overrun_d   = 1'b0;
`ifdef UART_RX_PARITY_EN
    parity_err_d = stop_sample & par_bad;
`endif
    if (rx_valid_q && rx.rx_ready) rx_valid_d = 1'b0;
    if (stop_sample && rxs_q && !par_bad) begin
      if (rx_valid_q && !rx.rx_ready) begin
        overrun_d = 1'b1;
      end else begin
        rx_valid_d = 1'b1;
        rx_data_d  = shift_q;
      end
    end
  end

  // Output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_valid_q   <= 1'b0;
      rx_data_q    <= 8'h00;
      frame_err_q  <= 1'b0;
      overrun_q    <= 1'b0;
`ifdef UART_RX_PARITY_EN
      parity_err_q <= 1'b0;
`endif
    end else begin
      rx_valid_q   <= rx_valid_d;
      rx_data_q    <= rx_data_d;
      frame_err_q  <= frame_err_d;
      overrun_q    <= overrun_d;
`ifdef UART_RX_PARITY_EN
      parity_err_q <= parity_err_d;
`endif
    end
  end

  assign rx.rx_valid  = rx_valid_q;
  assign rx.rx_data   = rx_data_q;
  assign rx.frame_err = frame_err_q;
  assign rx.overrun   = overrun_q;
`ifdef UART_RX_PARITY_EN
  assign rx.parity_err = parity_err_q;
`else
  assign rx.parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx at 1 MHz / 100 kbaud (10 clocks per bit).
// Directed frames cover latency, false start, framing error, overrun,
// same-cycle handshake and reset; a random phase is scored against a
// frame-level model of the one-byte buffer.
module tb_uart_rx;

  localparam int CLK_HZ = 1_000_000;
  localparam int BAUD   = 100_000;
  localparam int CPB    = CLK_HZ / BAUD;
`ifdef UART_RX_PARITY_EN
  localparam int NBITS = 11;
  localparam bit PAR   = 1'b1;
`else
  localparam int NBITS = 10;
  localparam bit PAR   = 1'b0;
`endif
  // Line drive to rx_valid: 2 synchronizer clocks plus the frame latency.
  localparam int LAT    = 2 + CPB / 2 + 9 * CPB + 1 + (PAR ? CPB : 0);
  // Frame cycle at which rx_ready must be high to coincide with the stop sample.
  localparam int HS_IDX = LAT - 1;

  logic clk;
  logic rst_n;
  logic rxd;

  uart_rx_if u_if ();

  uart_rx #(
    .clk_hz   (CLK_HZ),
    .baud_rate(BAUD)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .rxd  (rxd),
    .rx   (u_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  int frame_c0 = 0;

  // Observed activity, sampled mid-cycle
  int         ferr_cyc    = 0;
  int         ovr_cyc     = 0;
  int         perr_cyc    = 0;
  int         both_cyc    = 0;
  int         valid_cyc   = 0;
  int         valid_rises = 0;
  int         rise_cyc    = 0;
  logic       prev_valid  = 1'b0;
  logic [7:0] got_q[$];

  always @(posedge clk) cyc <= cyc + 1;

  always begin
    @(negedge clk);
    #2;
    if (u_if.frame_err === 1'b1) ferr_cyc++;
    if (u_if.overrun === 1'b1) ovr_cyc++;
    if (u_if.parity_err === 1'b1) perr_cyc++;
    if (u_if.frame_err === 1'b1 && u_if.parity_err === 1'b1) both_cyc++;
    if (u_if.rx_valid === 1'b1) valid_cyc++;
    if (u_if.rx_valid === 1'b1 && prev_valid !== 1'b1) begin
      valid_rises++;
      rise_cyc = cyc;
    end
    prev_valid = u_if.rx_valid;
    if (u_if.rx_valid === 1'b1 && u_if.rx_ready === 1'b1) got_q.push_back(u_if.rx_data);
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] last_got();
    if (got_q.size() == 0) return 32'hDEAD;
    return {24'h0, got_q[got_q.size() - 1]};
  endfunction

  task automatic settle(input int n);
    repeat (n) @(negedge clk);
    #4;
  endtask

  // Drive one frame; optionally pulse rx_ready for exactly one cycle at frame cycle ready_pulse.
  task automatic send_frame(input logic [7:0] b, input bit stop_b, input bit par_b, input int ready_pulse);
    int idx;
    for (int i = 0; i < NBITS; i++) begin
      for (int k = 0; k < CPB; k++) begin
        @(negedge clk);
        idx = i * CPB + k;
        if (idx == 0) frame_c0 = cyc;
        if (i == 0) rxd = 1'b0;
        else if (i <= 8) rxd = b[i - 1];
        else if (i == NBITS - 1) rxd = stop_b;
        else rxd = par_b;
        if (ready_pulse >= 0 && idx == ready_pulse) u_if.rx_ready = 1'b1;
        if (ready_pulse >= 0 && idx == ready_pulse + 1) u_if.rx_ready = 1'b0;
      end
    end
    @(negedge clk);
    rxd = 1'b1;
  endtask

  initial begin : main
    int         v0, vc0, f0, o0, p0, b0, g0;
    logic [7:0] rb;
    bit         rst_b, rpok, rr, pend;
    logic [7:0] pend_b;
    int         exp_f, exp_o, exp_p;
    logic [7:0] exp_q[$];

    rst_n = 1'b1;
    rxd   = 1'b1;
    u_if.rx_ready = 1'b1;
    #1 rst_n = 1'b0;

    // Reset values
    settle(3);
    check("reset_valid", u_if.rx_valid, 1'b0);
    check("reset_data", u_if.rx_data, 8'h00);
    check("reset_frame_err", u_if.frame_err, 1'b0);
    check("reset_overrun", u_if.overrun, 1'b0);
    check("reset_parity_err", u_if.parity_err, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    settle(5);

    // Clean frame 0xA5, consumer always ready
    v0 = valid_rises; vc0 = valid_cyc; f0 = ferr_cyc; o0 = ovr_cyc; p0 = perr_cyc;
    send_frame(8'hA5, 1'b1, ^8'hA5, -1);
    settle(3);
    check("a5_rises", valid_rises - v0, 1);
    check("a5_valid_cycles", valid_cyc - vc0, 1);
    check("a5_data", last_got(), 8'hA5);
    check("a5_latency", rise_cyc - frame_c0, LAT);
    check("a5_errors", (ferr_cyc - f0) + (ovr_cyc - o0) + (perr_cyc - p0), 0);

    // 3-cycle low glitch is a false start; receiver must be idle afterwards
    v0 = valid_rises; f0 = ferr_cyc; o0 = ovr_cyc; p0 = perr_cyc;
    @(negedge clk); rxd = 1'b0;
    repeat (3) @(negedge clk);
    rxd = 1'b1;
    settle(2 * CPB);
    check("glitch_no_valid", valid_rises - v0, 0);
    check("glitch_errors", (ferr_cyc - f0) + (ovr_cyc - o0) + (perr_cyc - p0), 0);
    send_frame(8'h96, 1'b1, ^8'h96, -1);
    settle(3);
    check("post_glitch_data", last_got(), 8'h96);
    check("post_glitch_latency", rise_cyc - frame_c0, LAT);

    // Stop bit low: framing error, byte dropped
    v0 = valid_rises; f0 = ferr_cyc; o0 = ovr_cyc;
    send_frame(8'h3C, 1'b0, ^8'h3C, -1);
    settle(3);
    check("ferr_pulse_cycles", ferr_cyc - f0, 1);
    check("ferr_no_valid", valid_rises - v0, 0);
    check("ferr_valid_low", u_if.rx_valid, 1'b0);
    check("ferr_no_overrun", ovr_cyc - o0, 0);

    // Overrun: consumer stalled across two good frames
    @(negedge clk); u_if.rx_ready = 1'b0;
    o0 = ovr_cyc; g0 = got_q.size();
    send_frame(8'h11, 1'b1, ^8'h11, -1);
    settle(3);
    check("ovr_first_valid", u_if.rx_valid, 1'b1);
    send_frame(8'h22, 1'b1, ^8'h22, -1);
    settle(3);
    check("ovr_pulse_cycles", ovr_cyc - o0, 1);
    check("ovr_valid_held", u_if.rx_valid, 1'b1);
    check("ovr_data_held", u_if.rx_data, 8'h11);
    @(negedge clk); u_if.rx_ready = 1'b1;
    settle(2);
    check("ovr_drain_valid", u_if.rx_valid, 1'b0);
    check("ovr_drain_count", got_q.size() - g0, 1);
    check("ovr_drain_data", last_got(), 8'h11);

    // Handshake in the same cycle as the stop sample: new byte loads, no overrun
    @(negedge clk); u_if.rx_ready = 1'b0;
    send_frame(8'h44, 1'b1, ^8'h44, -1);
    settle(3);
    o0 = ovr_cyc;
    send_frame(8'h55, 1'b1, ^8'h55, HS_IDX);
    settle(2);
    check("hs_valid", u_if.rx_valid, 1'b1);
    check("hs_data", u_if.rx_data, 8'h55);
    check("hs_no_overrun", ovr_cyc - o0, 0);
    check("hs_consumed_old", last_got(), 8'h44);
    @(negedge clk); u_if.rx_ready = 1'b1;
    settle(2);
    check("hs_consumed_new", last_got(), 8'h55);

    // Reset mid-frame with a byte pending; release with the line low
    @(negedge clk); u_if.rx_ready = 1'b0;
    send_frame(8'h33, 1'b1, ^8'h33, -1);
    settle(3);
    check("rst_pending_valid", u_if.rx_valid, 1'b1);
    v0 = valid_rises; f0 = ferr_cyc; o0 = ovr_cyc; p0 = perr_cyc; g0 = got_q.size();
    for (int k = 0; k < CPB; k++) begin @(negedge clk); rxd = 1'b0; end
    for (int k = 0; k < 3 * CPB; k++) begin @(negedge clk); rxd = 1'b1; end
    @(negedge clk);
    rst_n = 1'b0;
    rxd   = 1'b0;
    #4;
    check("rst_mid_valid", u_if.rx_valid, 1'b0);
    check("rst_mid_data", u_if.rx_data, 8'h00);
    check("rst_mid_errs", {u_if.frame_err, u_if.overrun, u_if.parity_err}, 3'b000);
    repeat (4) @(negedge clk);
    @(negedge clk); rst_n = 1'b1;
    repeat (2 * CPB) @(negedge clk);
    rxd = 1'b1;
    u_if.rx_ready = 1'b1;
    settle(12 * CPB);
    check("rst_no_frame", valid_rises - v0, 0);
    check("rst_no_errors", (ferr_cyc - f0) + (ovr_cyc - o0) + (perr_cyc - p0), 0);
    check("rst_nothing_consumed", got_q.size() - g0, 0);
    send_frame(8'h5A, 1'b1, ^8'h5A, -1);
    settle(3);
    check("rst_after_count", got_q.size() - g0, 1);
    check("rst_after_data", last_got(), 8'h5A);

`ifdef UART_RX_PARITY_EN
    // Even parity: 0x07 has three ones so the parity bit is 1
    v0 = valid_rises; p0 = perr_cyc; f0 = ferr_cyc; b0 = both_cyc;
    send_frame(8'h07, 1'b1, 1'b1, -1);
    settle(3);
    check("par_good_data", last_got(), 8'h07);
    check("par_good_no_err", perr_cyc - p0, 0);
    v0 = valid_rises;
    send_frame(8'h07, 1'b1, 1'b0, -1);
    settle(3);
    check("par_bad_pulse", perr_cyc - p0, 1);
    check("par_bad_no_valid", valid_rises - v0, 0);
    send_frame(8'h07, 1'b0, 1'b0, -1);
    settle(3);
    check("par_ferr_both", both_cyc - b0, 1);
    check("par_ferr_frame", ferr_cyc - f0, 1);
    check("par_ferr_no_valid", valid_rises - v0, 0);
`endif

    // Random frames scored against a frame-level buffer model
    got_q.delete();
    f0 = ferr_cyc; o0 = ovr_cyc; p0 = perr_cyc;
    exp_f = 0; exp_o = 0; exp_p = 0;
    pend = 1'b0; pend_b = 8'h00;
    for (int n = 0; n < 24; n++) begin
      rb    = 8'($urandom);
      rst_b = ($urandom_range(0, 4) != 0);
      rpok  = PAR ? ($urandom_range(0, 3) != 0) : 1'b1;
      rr    = 1'($urandom_range(0, 1));
      @(negedge clk); u_if.rx_ready = rr;
      if (rr && pend) begin exp_q.push_back(pend_b); pend = 1'b0; end
      if (!rst_b) exp_f++;
      if (!rpok) exp_p++;
      if (rst_b && rpok) begin
        if (pend) exp_o++;
        else begin pend = 1'b1; pend_b = rb; end
      end
      if (rr && pend) begin exp_q.push_back(pend_b); pend = 1'b0; end
      send_frame(rb, rst_b, rpok ? ^rb : ~^rb, -1);
      repeat ($urandom_range(3, 8)) @(negedge clk);
    end
    @(negedge clk); u_if.rx_ready = 1'b1;
    if (pend) exp_q.push_back(pend_b);
    settle(4);
    check("rand_count", got_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
      check($sformatf("rand_byte%0d", i), got_q[i], exp_q[i]);
    check("rand_frame_err", ferr_cyc - f0, exp_f);
    check("rand_overrun", ovr_cyc - o0, exp_o);
    check("rand_parity_err", perr_cyc - p0, exp_p);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
